// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
//   Request / response bundle between the execute stage and the iterative
//   multiply/divide unit. Signal suffixes are as seen from the unit (slave).
//
//   opr_a_i     rs1 operand / dividend
//   opr_b_i     rs2 operand / divisor
//   md_valid_i  request valid
//   md_func_i   op select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   word_op_i   W-form request (low 32 bits, sign-extended result)
//   md_ready_o  unit can accept a request
//   flush_i     kill any accepted or in-flight op
//   res_ready_i consumer accepts the result
//   valid_res_o result valid
//   md_res_o    result
// -----------------------------------------------------------------------------
interface muldiv_unit_if #(
    parameter int XLEN = 64
);
    logic [XLEN-1:0] opr_a_i;
    logic [XLEN-1:0] opr_b_i;
    logic            md_valid_i;
    logic [2:0]      md_func_i;
    logic            word_op_i;
    logic            md_ready_o;
    logic            flush_i;
    logic            res_ready_i;
    logic            valid_res_o;
    logic [XLEN-1:0] md_res_o;

    modport master (
        output opr_a_i, opr_b_i, md_valid_i, md_func_i, word_op_i,
        output flush_i, res_ready_i,
        input  md_ready_o, valid_res_o, md_res_o
    );

    modport slave (
        input  opr_a_i, opr_b_i, md_valid_i, md_func_i, word_op_i,
        input  flush_i, res_ready_i,
        output md_ready_o, valid_res_o, md_res_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV64M/RV32M multiply/divide unit for the execute stage.
//   Multiplies by MSB-first shift-add on operand magnitudes, divides by
//   restoring division on magnitudes, then applies sign correction.
//   BITS_PER_CYCLE multiplier/dividend bits are retired per cycle.
//   Divide-by-zero, signed overflow and the unencodable MULH*W forms
//   complete in a single cycle without entering BUSY.
//
//   Ports:
//     clk_i   clock, all state updates on the rising edge
//     rst_i   synchronous active-high reset
//     md      muldiv_unit_if.slave request/response bundle
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN           = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    muldiv_unit_if.slave md
);

    localparam int CNT_FULL = XLEN / BITS_PER_CYCLE;
    localparam int CNT_WORD = 32 / BITS_PER_CYCLE;
    localparam int CNT_W    = $clog2(CNT_FULL + 1);
    localparam int SHW      = XLEN - 32;

    localparam logic [XLEN-1:0] MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_WORD = ~(XLEN'(32'h7FFF_FFFF));

    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    // Sign-extend a 32-bit value to XLEN.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r = XLEN'(v);
        if (v[31]) begin
            r = r | ~(XLEN'(32'hFFFF_FFFF));
        end
        return r;
    endfunction

    // Operand as seen by the op: full width, or low word sign/zero-extended.
    function automatic logic [XLEN-1:0] ext_op(input logic [XLEN-1:0] v,
                                               input logic            word,
                                               input logic            sgn);
        logic [XLEN-1:0] r;
        r = v;
        if (word) begin
            r = sgn ? sext32(v[31:0]) : XLEN'(v[31:0]);
        end
        return r;
    endfunction

    // W-form results are always sign-extended from bit 31, unsigned ops too.
    function automatic logic [XLEN-1:0] fmt_res(input logic [XLEN-1:0] r,
                                                input logic            word);
        return word ? sext32(r[31:0]) : r;
    endfunction

    state_e state_q, state_d;

    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic [2*XLEN-1:0] acc_q,  acc_d;   // product (mul) / remainder in low half (div)
    logic [XLEN-1:0]   sh_q,   sh_d;    // multiplier (mul) / dividend -> quotient (div)
    logic [XLEN-1:0]   m_q,    m_d;     // multiplicand (mul) / divisor (div)
    logic [2:0]        func_q, func_d;
    logic              word_q, word_d;
    logic              neg_q,  neg_d;   // selected result needs negation
    logic [XLEN-1:0]   res_q,  res_d;

    // ------------------------------------------------------------------
    // Request decode and single-cycle special cases
    // ------------------------------------------------------------------
    logic [2:0]      f;
    logic            word_eff, is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_op, b_op, a_mag, b_mag, spec_res;
    logic            div_zero, div_ovf, mulh_w, special, accept;

    always_comb begin
        f        = md.md_func_i;
        word_eff = (XLEN > 32) ? md.word_op_i : 1'b0;
        is_div   = f[2];
        a_sgn    = (f == F_MULH) || (f == F_MULHSU) || (f == F_DIV) || (f == F_REM);
        b_sgn    = (f == F_MULH) || (f == F_DIV) || (f == F_REM);
        a_op     = ext_op(md.opr_a_i, word_eff, a_sgn);
        b_op     = ext_op(md.opr_b_i, word_eff, b_sgn);
        a_neg    = a_sgn & a_op[XLEN-1];
        b_neg    = b_sgn & b_op[XLEN-1];
        a_mag    = a_neg ? -a_op : a_op;
        b_mag    = b_neg ? -b_op : b_op;

        div_zero = is_div && (b_op == '0);
        // Only signed DIV/REM (func[0]==0) can overflow.
        div_ovf  = is_div && !f[0] && !div_zero &&
                   (a_op == (word_eff ? MIN_WORD : MIN_FULL)) && (b_op == '1);
        mulh_w   = !is_div && word_eff && (f[1:0] != 2'b00);
        special  = div_zero || div_ovf || mulh_w;

        spec_res = '0;
        if (div_zero) begin
            spec_res = f[1] ? a_op : '1;
        end else if (div_ovf) begin
            spec_res = f[1] ? '0 : a_op;
        end
        spec_res = fmt_res(spec_res, word_eff);

        accept = (state_q == S_IDLE) && md.md_valid_i && !md.flush_i;
    end

    // ------------------------------------------------------------------
    // One BUSY iteration: BITS_PER_CYCLE steps of shift-add or restoring
    // division, plus the sign-corrected result used on the last one.
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] p_nx, prod, acc_it;
    logic [XLEN:0]     r_wide;
    logic [XLEN-1:0]   r_nx, s_nx, quo, rem, sel, fin_res;
    logic              qb;

    always_comb begin
        p_nx   = acc_q;
        r_nx   = acc_q[XLEN-1:0];
        s_nx   = sh_q;
        r_wide = '0;
        qb     = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (func_q[2]) begin
                r_wide = {r_nx, s_nx[XLEN-1]};
                qb     = (r_wide >= {1'b0, m_q});
                if (qb) begin
                    r_wide = r_wide - {1'b0, m_q};
                end
                r_nx = r_wide[XLEN-1:0];
                s_nx = {s_nx[XLEN-2:0], qb};
            end else begin
                p_nx = {p_nx[2*XLEN-2:0], 1'b0} +
                       (s_nx[XLEN-1] ? {{XLEN{1'b0}}, m_q} : {(2*XLEN){1'b0}});
                s_nx = {s_nx[XLEN-2:0], 1'b0};
            end
        end
        acc_it = func_q[2] ? {{XLEN{1'b0}}, r_nx} : p_nx;

        prod = neg_q ? -p_nx : p_nx;
        quo  = neg_q ? -s_nx : s_nx;
        rem  = neg_q ? -r_nx : r_nx;
        if (func_q[2]) begin
            sel = func_q[1] ? rem : quo;
        end else begin
            sel = (func_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
        fin_res = fmt_res(sel, word_q);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. Flush beats res_ready and the iteration count.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = special ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (md.flush_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (md.flush_i || md.res_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs. Valid is masked by flush in the same cycle.
    always_comb begin
        md.md_ready_o  = (state_q == S_IDLE) && !rst_i;
        md.valid_res_o = (state_q == S_DONE) && !md.flush_i && !rst_i;
    end

    assign md.md_res_o = res_q;

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        sh_d   = sh_q;
        m_d    = m_q;
        func_d = func_q;
        word_d = word_q;
        neg_d  = neg_q;
        res_d  = res_q;
        if (accept) begin
            func_d = f;
            word_d = word_eff;
            // Remainder follows the dividend; everything else follows a^b.
            neg_d  = (is_div && f[1]) ? a_neg : (a_neg ^ b_neg);
            cnt_d  = word_eff ? CNT_W'(CNT_WORD) : CNT_W'(CNT_FULL);
            acc_d  = '0;
            // Word operands are pre-aligned to the top so that the MSB-first
            // loop finishes after 32 bits with the result already in place.
            if (is_div) begin
                sh_d = word_eff ? (a_mag << SHW) : a_mag;
                m_d  = b_mag;
            end else begin
                sh_d = word_eff ? (b_mag << SHW) : b_mag;
                m_d  = a_mag;
            end
            if (special) begin
                res_d = spec_res;
            end
        end else if (state_q == S_BUSY) begin
            cnt_d = cnt_q - CNT_W'(1);
            acc_d = acc_it;
            sh_d  = s_nx;
            if (cnt_q == CNT_W'(1)) begin
                res_d = fin_res;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            sh_q   <= '0;
            m_q    <= '0;
            func_q <= '0;
            word_q <= 1'b0;
            neg_q  <= 1'b0;
            res_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            sh_q   <= sh_d;
            m_q    <= m_d;
            func_q <= func_d;
            word_q <= word_d;
            neg_q  <= neg_d;
            res_q  <= res_d;
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative integer multiply/divide unit for the execute stage. Implements RV64M/RV32M: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, plus the W-suffixed word forms.
- Parametrised in datapath width and bits retired per cycle.
- Sits beside the single-cycle ALU.
- Uses a valid/ready handshake on both sides and honours pipeline flush.

Parameters:
- XLEN, 64, datapath width; legal values are 32 or 64.
- BITS_PER_CYCLE, 1, operand bits processed per iteration; legal values are 1, 2 or 4; must divide 32.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- opr_a_i  input  XLEN  rs1 operand / dividend.
- opr_b_i  input  XLEN  rs2 operand / divisor.
- md_valid_i  input  1  request valid.
- md_func_i  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- word_op_i  input  1  W-form: use the low 32 bits; result is sign-extended from bit 31.
- md_ready_o  output  1  unit can accept a request.
- flush_i  input  1  kill any accepted or in-flight op.
- res_ready_i  input  1  consumer accepts the result.
- valid_res_o  output  1  result valid.
- md_res_o  output  XLEN  result.

Behaviour:
- Reset
  - rst_i high at an edge forces state to IDLE and clears all internal registers.
  - While rst_i is high: md_ready_o=0, valid_res_o=0.
  - md_res_o=0 until the first result.
  - Reset mid-operation abandons the op; no result is produced.
- States
  - IDLE: md_ready_o=1. On md_valid_i & ~flush_i, capture operands, func and word_op.
    - Special case → DONE.
    - Otherwise → BUSY with iteration counter = W/BITS_PER_CYCLE, where W = 32 if word_op_i else XLEN.
  - BUSY: md_ready_o=0. One iteration per cycle, with the counter decrementing. When the counter reaches 1, the final iteration completes and the next state is DONE.
  - DONE: valid_res_o=1 and md_res_o stable. On res_ready_i → IDLE. Otherwise hold both result and valid.
  - No accept in DONE: md_ready_o is low in DONE even when res_ready_i is high.
- Latency
  - Request accepted at edge T; normal ops assert valid_res_o in cycle T+W/BITS_PER_CYCLE+1.
  - Special cases assert valid_res_o in cycle T+1.
- Multiply
  - Shift-add on the operand magnitudes; 2W-bit product.
  - MUL returns the low W bits. MULH/MULHSU/MULHU return the high W bits.
  - Signedness: MULH is s×s, MULHSU is s×u, MULHU is u×u. Sign correction is applied to the magnitude product.
- Divide
  - Restoring or non-restoring division on magnitudes.
  - The quotient takes the sign of a^b. The remainder takes the sign of the dividend.
  - DIVU/REMU are unsigned.
- Special cases (single cycle, no BUSY)
  - Divisor = 0: quotient = all ones (W bits), remainder = dividend.
  - Signed overflow (dividend = most-negative W-bit value, divisor = -1): quotient = dividend, remainder = 0.
  - word_op_i with MULH/MULHSU/MULHU (no RV encoding): result 0.
- Word ops
  - Operands are the low 32 bits, sign- or zero-extended per op signedness.
  - Final md_res_o = {{(XLEN-32){r[31]}}, r[31:0]}. This also applies to DIVUW/REMUW.
  - When XLEN=32, word_op_i is ignored.
- Flush
  - valid_res_o = (state==DONE) & ~flush_i, masked combinationally in the same cycle.
  - flush_i at an edge in BUSY or DONE → IDLE; the result is discarded.
  - flush_i in IDLE blocks the accept.
  - Flush takes priority over res_ready_i.
- md_res_o is don't-care outside DONE, but must not glitch while valid_res_o is high.

Test Plan:
- MUL: XLEN=64, BPC=1, MUL a=7, b=-3 → valid_res_o exactly 65 cycles after accept, md_res_o=0xFFFF_FFFF_FFFF_FFEB; held while res_ready_i=0 for 5 cycles, then IDLE the cycle after res_ready_i=1.
- High-half multiplies: MULHU a=b=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE; MULH same operands → 0; MULHSU a=-1, b=2 → 0xFFFF_FFFF_FFFF_FFFF.
- Signed divide: DIV a=-7, b=2 → -3; REM a=-7, b=2 → -1; DIVU a=7, b=0 → all ones at T+1; REM a=5, b=0 → 5; DIV a=0x8000_0000_0000_0000, b=-1 → 0x8000_0000_0000_0000, REM → 0.
- Word ops: DIVW a=0x0000_0001_8000_0000, b=-1 → 0xFFFF_FFFF_8000_0000 at T+1; MULW a=0x4000_0000, b=2 → 0xFFFF_FFFF_8000_0000 after 33 cycles; MULHW → 0.
- Flush: flush_i asserted mid-BUSY (cycle 20) → no valid_res_o; md_ready_o=1 next cycle; a new DIVU 100/7 → 14 with correct latency. flush_i in DONE → valid_res_o drops the same cycle. flush_i with md_valid_i in IDLE → not accepted.
- Params and reset: rerun the directed set with BITS_PER_CYCLE=4 (latency 17 for XLEN=64, 9 for word) and XLEN=32 (latency 33). Assert rst_i mid-BUSY → outputs zero, no result after release.
